// File: rtl/block_ram_pkg.sv
// Shared types for the two-requester block RAM arbiter: FSM states, the latched
// request record and a small grant-index helper.
package block_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic [1:0] onehot2(input logic id);
        if (id) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/block_ram_arbiter_if.sv
// Request/response bundle for both clients plus the RAM port. The arbiter uses
// the master view; clients and the RAM model sit on the slave view.
interface block_ram_arbiter_if #(
    parameter int ADDR_WIDTH = block_ram_pkg::ADDR_W,
    parameter int DATA_WIDTH = block_ram_pkg::DATA_W
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_write;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  ram_read;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_datai;
    logic [DATA_WIDTH-1:0] ram_datao;

    modport master (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, ram_datao,
        output req_ready, rsp_valid, rsp_rdata, ram_read, ram_write, ram_addr, ram_datai
    );

    modport slave (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, ram_datao,
        input  req_ready, rsp_valid, rsp_rdata, ram_read, ram_write, ram_addr, ram_datai
    );

endinterface

// File: rtl/block_ram_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie is settled by
// the pointer (0 favours requester 0).
module block_ram_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // Purely combinational one-hot grant.
    always_comb begin
        case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/block_ram_arbiter.sv
// Shares one single-port block RAM between two requesters. One access is in
// flight at a time; each completes with a single response pulse to its owner.
module block_ram_arbiter #(
    parameter int ADDR_WIDTH = block_ram_pkg::ADDR_W,
    parameter int DATA_WIDTH = block_ram_pkg::DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    block_ram_arbiter_if.master bus
);
    import block_ram_pkg::*;

    localparam int              CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  gnt_id_q, gnt_id_d;
    req_t                  req_q, req_d;
    logic                  ram_read_q, ram_read_d;
    logic                  ram_write_q, ram_write_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]            gnt_s;
    logic [1:0]            ready_s;
    logic                  accept_s;
    logic                  wr_in_s;
    logic [ADDR_WIDTH-1:0] addr_in_s;
    logic [DATA_WIDTH-1:0] wdata_in_s;

    block_ram_rr_arb2 u_rr (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_s)
    );

    // Winner's request fields and the accept condition.
    always_comb begin
        accept_s = (state_q == IDLE) && (gnt_s != 2'b00);
        if (gnt_s[1]) begin
            wr_in_s    = bus.req_write[1];
            addr_in_s  = bus.req_addr1;
            wdata_in_s = bus.req_wdata1;
        end else begin
            wr_in_s    = bus.req_write[0];
            addr_in_s  = bus.req_addr0;
            wdata_in_s = bus.req_wdata0;
        end
    end

    // Ready is the only combinational output; held low while reset is asserted.
    always_comb begin
        if ((state_q == IDLE) && !rst_i) begin
            ready_s = gnt_s;
        end else begin
            ready_s = 2'b00;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            gnt_id_q    <= 1'b0;
            req_q       <= '{write: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_id_q    <= gnt_id_d;
            req_q       <= req_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic: sequencing, latency counter and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = ISSUE;
                    gnt_id_d = gnt_s[1];
                    ptr_d    = ~gnt_s[1];
                end else begin
                    state_d  = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = req_q.write ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output logic: next values of the registered RAM strobes, address/data and
    // response. The latched address/data drive the RAM only during ISSUE and are
    // cleared on the way out so the port idles at zero.
    always_comb begin
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = {DATA_WIDTH{1'b0}};
        req_d       = '{write: req_q.write, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    ram_read_d  = ~wr_in_s;
                    ram_write_d = wr_in_s;
                    req_d       = '{write: wr_in_s,
                                    addr:  addr_in_s,
                                    wdata: wr_in_s ? wdata_in_s : {DATA_WIDTH{1'b0}}};
                end else begin
                    ram_read_d  = 1'b0;
                end
            end
            ISSUE: begin
                if (req_q.write) begin
                    rsp_valid_d = onehot2(gnt_id_q);
                end else begin
                    rsp_valid_d = 2'b00;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = onehot2(gnt_id_q);
                    rsp_rdata_d = bus.ram_datao;
                end else begin
                    rsp_valid_d = 2'b00;
                end
            end
            RESP: begin
                rsp_valid_d = 2'b00;
            end
            default: begin
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_read  = ram_read_q;
    assign bus.ram_write = ram_write_q;
    assign bus.ram_addr  = req_q.addr;
    assign bus.ram_datai = req_q.wdata;

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Directed bench for block_ram_arbiter: one instance with RD_LATENCY=1 and one
// with RD_LATENCY=3, each driving a small synchronous RAM model.
module tb_block_ram_arbiter;

    logic clk;
    logic rst;
    logic ram_init;
    int   vectors;
    int   miscompares;

    block_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();
    block_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if3 ();

    block_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) dut1 (
        .clk_i (clk), .rst_i (rst), .bus (if1.master)
    );
    block_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3)) dut3 (
        .clk_i (clk), .rst_i (rst), .bus (if3.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: contents preset to addr ^ 0x5A; read data after 1 or 3 edges.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] dout1, p0, p1, p2;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'(i) ^ 8'h5A;
                mem3[i] <= 8'(i) ^ 8'h5A;
            end
        end else begin
            if (if1.ram_write) mem1[if1.ram_addr] <= if1.ram_datai;
            if (if3.ram_write) mem3[if3.ram_addr] <= if3.ram_datai;
        end
        if (if1.ram_read) dout1 <= mem1[if1.ram_addr];
        if (if3.ram_read) p0 <= mem3[if3.ram_addr];
        p1 <= p0;
        p2 <= p1;
    end
    assign if1.ram_datao = dout1;
    assign if3.ram_datao = p2;

    logic [29:0] obs1, obs3;
    assign obs1 = {if1.ram_read, if1.ram_write, if1.ram_addr, if1.ram_datai,
                   if1.rsp_valid, if1.rsp_rdata, if1.req_ready};
    assign obs3 = {if3.ram_read, if3.ram_write, if3.ram_addr, if3.ram_datai,
                   if3.rsp_valid, if3.rsp_rdata, if3.req_ready};

    function automatic logic [29:0] pk(input logic rd, input logic wr, input logic [7:0] a,
                                       input logic [7:0] di, input logic [1:0] rv,
                                       input logic [7:0] rdat, input logic [1:0] rdy);
        return {rd, wr, a, di, rv, rdat, rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] e;
        if1.req_valid = 2'b01; if1.req_write = 2'b00; if1.req_addr0 = 8'h10;
        #1;
        e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL reset_pre: got %h expected %h", obs1, e); end
        tick();
        e = pk(1'b1, 1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL reset_issue: got %h expected %h", obs1, e); end
        rst = 1'b1; if1.req_valid = 2'b11; if1.req_addr1 = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (obs1 !== 30'h0) begin miscompares++; $display("FAIL reset_hold%0d: got %h expected 0", i, obs1); end
        end
        rst = 1'b0;
        #1;
        e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL reset_first_grant: got %h expected %h", obs1, e); end
        tick();
        if1.req_valid = 2'b00;
        e = pk(1'b1, 1'b0, 8'h10, 8'h00, 2'b00, 8'h00, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL reset_reissue: got %h expected %h", obs1, e); end
        tick(); tick();
        e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h4A, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL reset_rsp: got %h expected %h", obs1, e); end
        tick();
    endtask

    task automatic test_write_read();
        logic [29:0] e;
        if1.req_valid = 2'b01; if1.req_write = 2'b01; if1.req_addr0 = 8'h05; if1.req_wdata0 = 8'hA5;
        #1;
        vectors++; if (if1.req_ready !== 2'b01) begin miscompares++; $display("FAIL wr_ready: got %b expected 01", if1.req_ready); end
        tick();
        if1.req_valid = 2'b00;
        e = pk(1'b0, 1'b1, 8'h05, 8'hA5, 2'b00, 8'h00, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL wr_strobe: got %h expected %h", obs1, e); end
        tick();
        e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h00, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL wr_rsp: got %h expected %h", obs1, e); end
        tick();
        if1.req_valid = 2'b01; if1.req_write = 2'b00;
        #1;
        vectors++; if (if1.req_ready !== 2'b01) begin miscompares++; $display("FAIL rd_ready_t3: got %b expected 01", if1.req_ready); end
        tick();
        if1.req_valid = 2'b00;
        e = pk(1'b1, 1'b0, 8'h05, 8'h00, 2'b00, 8'h00, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL rd_strobe: got %h expected %h", obs1, e); end
        tick();
        vectors++; if (obs1 !== 30'h0) begin miscompares++; $display("FAIL rd_wait: got %h expected 0", obs1); end
        tick();
        e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'hA5, 2'b00);
        vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL rd_rsp: got %h expected %h", obs1, e); end
        tick();
    endtask

    task automatic test_fairness();
        logic [29:0] e;
        logic        k;
        int          n0, n1;
        n0 = 0; n1 = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        if1.req_valid = 2'b11; if1.req_write = 2'b00; if1.req_addr0 = 8'h20; if1.req_addr1 = 8'h21;
        for (int c = 0; c < 32; c++) begin
            #1;
            k = 1'(c / 4);
            case (c % 4)
                0:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, k ? 2'b10 : 2'b01);
                1:       e = pk(1'b1, 1'b0, k ? 8'h21 : 8'h20, 8'h00, 2'b00, 8'h00, 2'b00);
                3:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, k ? 2'b10 : 2'b01, k ? 8'h7B : 8'h7A, 2'b00);
                default: e = 30'h0;
            endcase
            vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL rr_cycle%0d: got %h expected %h", c, obs1, e); end
            if (if1.rsp_valid[0]) n0++;
            if (if1.rsp_valid[1]) n1++;
            tick();
        end
        if1.req_valid = 2'b00;
        vectors++; if (n0 !== 4 || n1 !== 4) begin miscompares++; $display("FAIL rr_counts: got %0d/%0d expected 4/4", n0, n1); end
    endtask

    task automatic test_only_req1();
        logic [29:0] e;
        if1.req_valid = 2'b01; if1.req_write = 2'b00; if1.req_addr0 = 8'h10;
        tick();
        if1.req_valid = 2'b00;
        tick(); tick(); tick();
        if1.req_valid = 2'b10; if1.req_addr1 = 8'h30;
        for (int c = 0; c < 8; c++) begin
            #1;
            case (c % 4)
                0:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 2'b10);
                1:       e = pk(1'b1, 1'b0, 8'h30, 8'h00, 2'b00, 8'h00, 2'b00);
                3:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b10, 8'h6A, 2'b00);
                default: e = 30'h0;
            endcase
            vectors++; if (obs1 !== e) begin miscompares++; $display("FAIL req1_cycle%0d: got %h expected %h", c, obs1, e); end
            tick();
        end
        if1.req_valid = 2'b00;
    endtask

    task automatic test_latency3();
        logic [29:0] e;
        if3.req_valid = 2'b01; if3.req_write = 2'b00; if3.req_addr0 = 8'h3F;
        for (int c = 0; c < 7; c++) begin
            #1;
            case (c)
                0:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01);
                1:       e = pk(1'b1, 1'b0, 8'h3F, 8'h00, 2'b00, 8'h00, 2'b00);
                5:       e = pk(1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h65, 2'b00);
                default: e = 30'h0;
            endcase
            vectors++; if (obs3 !== e) begin miscompares++; $display("FAIL lat3_cycle%0d: got %h expected %h", c, obs3, e); end
            tick();
            if3.req_valid = 2'b00;
        end
    endtask

    task automatic test_random();
        logic [7:0] sb [256];
        logic       ptr, g, wr, got;
        logic [1:0] v;
        logic [7:0] a, d, er;
        for (int i = 0; i < 256; i++) sb[i] = 8'(i) ^ 8'h5A;
        ptr = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            if1.req_valid  = v;
            if1.req_write  = 2'($urandom_range(0, 3));
            if1.req_addr0  = 8'h40 + 8'($urandom_range(0, 7));
            if1.req_addr1  = 8'h40 + 8'($urandom_range(0, 7));
            if1.req_wdata0 = 8'($urandom_range(0, 255));
            if1.req_wdata1 = 8'($urandom_range(0, 255));
            #1;
            g  = (v == 2'b11) ? ptr : v[1];
            wr = g ? if1.req_write[1] : if1.req_write[0];
            a  = g ? if1.req_addr1 : if1.req_addr0;
            d  = g ? if1.req_wdata1 : if1.req_wdata0;
            ptr = ~g;
            if (wr) begin sb[a] = d; er = 8'h00; end
            else begin er = sb[a]; end
            vectors++; if (if1.req_ready !== (g ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rnd%0d_ready: got %b expected g=%0d", n, if1.req_ready, g); end
            tick();
            if1.req_valid = 2'b00;
            vectors++; if ({if1.ram_read, if1.ram_write, if1.ram_addr, if1.ram_datai} !== {~wr, wr, a, wr ? d : 8'h00}) begin
                miscompares++; $display("FAIL rnd%0d_issue: got %b%b %h %h expected wr=%0d %h %h", n, if1.ram_read, if1.ram_write, if1.ram_addr, if1.ram_datai, wr, a, d);
            end
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                tick();
                vectors++; if (if1.ram_read && if1.ram_write) begin miscompares++; $display("FAIL rnd%0d_both_strobes: got 11 expected not both", n); end
                got = (if1.rsp_valid != 2'b00);
            end
            vectors++;
            if (!got) begin
                miscompares++; $display("FAIL rnd%0d_timeout: got no response expected one within 6 cycles", n);
            end else if ({if1.rsp_valid, if1.rsp_rdata} !== {(g ? 2'b10 : 2'b01), er}) begin
                miscompares++; $display("FAIL rnd%0d_rsp: got %b %h expected g=%0d %h", n, if1.rsp_valid, if1.rsp_rdata, g, er);
            end
            tick();
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; ram_init = 1'b1;
        if1.req_valid = 2'b00; if1.req_write = 2'b00; if1.req_addr0 = 8'h00; if1.req_addr1 = 8'h00;
        if1.req_wdata0 = 8'h00; if1.req_wdata1 = 8'h00;
        if3.req_valid = 2'b00; if3.req_write = 2'b00; if3.req_addr0 = 8'h00; if3.req_addr1 = 8'h00;
        if3.req_wdata0 = 8'h00; if3.req_wdata1 = 8'h00;
        repeat (3) tick();
        ram_init = 1'b0; rst = 1'b0;
        test_reset();
        test_write_read();
        test_fairness();
        test_only_req1();
        test_latency3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
